// File: rtl/cordic_outp_checker.sv
// CORDIC rotation-mode result checker: compares each XN/YN sample against a 16-entry
// golden table and reports mismatches and pass/fail. Watchdog enabled by CORDIC_CHK_TIMEOUT_EN.

module cordic_outp_checker #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TOL     = 2,
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             nGrst,
  input  logic             start,
  input  logic             dut_valid,
  input  logic [WIDTH-1:0] dut_x,
  input  logic [WIDTH-1:0] dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       err_cnt,
  output logic [3:0]       idx,
  output logic             mismatch,
  output logic             timeout
);

  localparam int unsigned DW = WIDTH + 1;
  localparam logic [3:0]  LAST_IDX = 4'(NUM_VEC - 1);
  localparam logic [4:0]  ERR_MAX = 5'd31;

  localparam logic signed [31:0] GA = 32'sd536870912;
  localparam logic signed [31:0] GC = 32'sd496004047;
  localparam logic signed [31:0] GS = 32'sd205451603;
  localparam logic signed [31:0] GH = 32'sd379625062;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // X component of the golden vector for angle 180 deg + k*22.5 deg
  function automatic logic signed [31:0] goldXTab(input logic [3:0] k);
    case (k)
      4'd0:  goldXTab = -GA;
      4'd1:  goldXTab = -GC;
      4'd2:  goldXTab = -GH;
      4'd3:  goldXTab = -GS;
      4'd4:  goldXTab = 32'sd0;
      4'd5:  goldXTab = GS;
      4'd6:  goldXTab = GH;
      4'd7:  goldXTab = GC;
      4'd8:  goldXTab = GA;
      4'd9:  goldXTab = GC;
      4'd10: goldXTab = GH;
      4'd11: goldXTab = GS;
      4'd12: goldXTab = 32'sd0;
      4'd13: goldXTab = -GS;
      4'd14: goldXTab = -GH;
      4'd15: goldXTab = -GC;
    endcase
  endfunction

  state_t                 state;
  logic                   s1Valid, s1Fail, s1Last;
  logic signed [WIDTH-1:0] goldX, goldY;
  logic signed [DW-1:0]   diffX, diffY;
  logic [DW-1:0]          absX, absY;
  logic                   sampleFail, stageErr;

  // sin(a) = cos(a - 90 deg), i.e. the Y column is the X column four entries back
  always_comb begin
    goldX      = WIDTH'(goldXTab(idx));
    goldY      = WIDTH'(goldXTab(idx - 4'd4));
    diffX      = $signed({dut_x[WIDTH-1], dut_x}) - $signed({goldX[WIDTH-1], goldX});
    diffY      = $signed({dut_y[WIDTH-1], dut_y}) - $signed({goldY[WIDTH-1], goldY});
    absX       = diffX[WIDTH] ? -diffX : diffX;
    absY       = diffY[WIDTH] ? -diffY : diffY;
    sampleFail = (absX > DW'(TOL)) || (absY > DW'(TOL));
    stageErr   = s1Valid && s1Fail && (err_cnt != ERR_MAX);
  end

`ifdef CORDIC_CHK_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [WD_W-1:0] wdCnt, wdNext;
  logic            wdExpire;
  assign wdNext   = wdCnt + WD_W'(1);
  assign wdExpire = (wdNext == WD_W'(TIMEOUT));
`else
  assign timeout = 1'b0;
`endif

  // Run control; compare results retire one cycle after the sample is accepted
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= 5'd0;
      idx      <= 4'd0;
      mismatch <= 1'b0;
      s1Valid  <= 1'b0;
      s1Fail   <= 1'b0;
      s1Last   <= 1'b0;
`ifdef CORDIC_CHK_TIMEOUT_EN
      timeout  <= 1'b0;
      wdCnt    <= '0;
`endif
    end else begin
      mismatch <= s1Valid && s1Fail;
      if (stageErr) err_cnt <= err_cnt + 5'd1;
      s1Valid <= 1'b0;
      s1Fail  <= 1'b0;
      s1Last  <= 1'b0;
      if (start) begin
        state    <= RUN;
        busy     <= 1'b1;
        done     <= 1'b0;
        pass     <= 1'b0;
        err_cnt  <= 5'd0;
        idx      <= 4'd0;
        mismatch <= 1'b0;
`ifdef CORDIC_CHK_TIMEOUT_EN
        timeout  <= 1'b0;
        wdCnt    <= '0;
`endif
      end else if (state == RUN) begin
        if (s1Last) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_cnt == 5'd0) && !(s1Valid && s1Fail);
        end else if (dut_valid) begin
          idx     <= idx + 4'd1;
          s1Valid <= 1'b1;
          s1Fail  <= sampleFail;
          s1Last  <= (idx == LAST_IDX);
`ifdef CORDIC_CHK_TIMEOUT_EN
          wdCnt   <= '0;
        end else if (wdExpire) begin
          state   <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= 1'b0;
          timeout <= 1'b1;
        end else begin
          wdCnt   <= wdNext;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_outp_checker.sv
// Bench for cordic_outp_checker: directed test-plan cases plus randomized runs, with a
// sample-level reference model checked against every DUT output each cycle.

module tb_cordic_outp_checker;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TOL     = 2;
  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned TIMEOUT = 1023;

  localparam longint GA = 536870912;
  localparam longint GC = 496004047;
  localparam longint GS = 205451603;
  localparam longint GH = 379625062;

  logic        clk = 1'b0;
  logic        nGrst = 1'b0;
  logic        start = 1'b0;
  logic        dut_valid = 1'b0;
  logic [31:0] dut_x = '0;
  logic [31:0] dut_y = '0;
  logic        busy, done, pass, mismatch, timeout;
  logic [4:0]  err_cnt;
  logic [3:0]  idx;

  cordic_outp_checker #(
    .WIDTH(WIDTH), .TOL(TOL), .NUM_VEC(NUM_VEC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .nGrst(nGrst), .start(start), .dut_valid(dut_valid),
    .dut_x(dut_x), .dut_y(dut_y), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .idx(idx), .mismatch(mismatch), .timeout(timeout)
  );

  always #5 clk = ~clk;

  longint goldX[16];
  longint goldY[16];
  longint offX[16];
  longint offY[16];
  int     gapV[16];
  int     tests = 0;
  int     fails = 0;
  bit     chkEn = 1'b0;

  // Reference model: run progress in samples, errors as a plain count
  bit mRun, mFinish, mPend, mPendFail;
  int mCount, mIdle, eErr;
  bit eBusy, eDone, ePass, eMis, eTo;

  function automatic longint absL(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit sampleBad(input int k, input logic [31:0] x, input logic [31:0] y);
    longint dx, dy;
    dx = longint'($signed(x)) - goldX[k];
    dy = longint'($signed(y)) - goldY[k];
    return (absL(dx) > longint'(TOL)) || (absL(dy) > longint'(TOL));
  endfunction

  task automatic modelReset();
    mRun = 0; mFinish = 0; mPend = 0; mPendFail = 0;
    mCount = 0; mIdle = 0; eErr = 0;
    eBusy = 0; eDone = 0; ePass = 0; eMis = 0; eTo = 0;
  endtask

  task automatic modelStep();
    eMis = mPend && mPendFail;
    if (eMis && eErr < 31) eErr++;
    mPend = 0;
    if (start) begin
      mRun = 1; mFinish = 0; mCount = 0; mIdle = 0;
      eBusy = 1; eDone = 0; ePass = 0; eErr = 0; eMis = 0; eTo = 0;
    end else if (mRun) begin
      if (mFinish) begin
        mRun = 0; eBusy = 0; eDone = 1; ePass = (eErr == 0);
      end else if (dut_valid) begin
        mPend = 1;
        mPendFail = sampleBad(mCount % 16, dut_x, dut_y);
        mCount++;
        mIdle = 0;
        if (mCount == int'(NUM_VEC)) mFinish = 1;
      end else begin
        mIdle++;
`ifdef CORDIC_CHK_TIMEOUT_EN
        if (mIdle == int'(TIMEOUT)) begin
          mRun = 0; eBusy = 0; eDone = 1; ePass = 0; eTo = 1;
        end
`endif
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge nGrst);
    if (!nGrst) modelReset();
    else modelStep();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chkEn) begin
      chk("busy", 32'(busy), 32'(eBusy));
      chk("done", 32'(done), 32'(eDone));
      chk("pass", 32'(pass), 32'(ePass));
      chk("err_cnt", 32'(err_cnt), 32'(eErr));
      chk("idx", 32'(idx), 32'(mCount % 16));
      chk("mismatch", 32'(mismatch), 32'(eMis));
      chk("timeout", 32'(timeout), 32'(eTo));
    end
  end

  task automatic sendSample(input int k, input longint ox, input longint oy);
    dut_valid = 1'b1;
    dut_x = 32'(goldX[k] + ox);
    dut_y = 32'(goldY[k] + oy);
    @(negedge clk);
    dut_valid = 1'b0;
    dut_x = $urandom();
    dut_y = $urandom();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clearOffs();
    for (int i = 0; i < 16; i++) begin
      offX[i] = 0; offY[i] = 0; gapV[i] = 0;
    end
  endtask

  task automatic waitDone(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_wait", 32'(done), 32'd1);
  endtask

  task automatic runVec();
    int n;
    pulseStart();
    for (int k = 0; k < int'(NUM_VEC); k++) begin
      idle(gapV[k]);
      sendSample(k, offX[k], offY[k]);
    end
    waitDone(40, n);
  endtask

  function automatic longint pickOff();
    int r;
    r = $urandom_range(0, 15);
    case (r)
      0: return 1;
      1: return -1;
      2: return 2;
      3: return -2;
      4: return 3;
      5: return -3;
      6: return 100;
      7: return -(longint'(1) << 20);
      default: return 0;
    endcase
  endfunction

  initial begin
    int n;
    int expErr;
    goldX = '{-GA, -GC, -GH, -GS, 0, GS, GH, GC, GA, GC, GH, GS, 0, -GS, -GH, -GC};
    goldY = '{0, -GS, -GH, -GC, -GA, -GC, -GH, -GS, 0, GS, GH, GC, GA, GC, GH, GS};
    clearOffs();

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    nGrst = 1'b1;
    chkEn = 1'b1;

    // valids before any start are ignored
    sendSample(0, 77, 0);
    sendSample(1, 0, 0);
    idle(2);
    chk("idle_ignore_idx", 32'(idx), 32'd0);

    // exact golden samples back to back
    pulseStart();
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int k = 0; k < 16; k++) sendSample(k, 0, 0);
    waitDone(40, n);
    chk("done_latency", 32'(15 + n), 32'(NUM_VEC));
    chk("clean_pass", 32'(pass), 32'd1);
    chk("clean_err", 32'(err_cnt), 32'd0);
    chk("clean_busy_low", 32'(busy), 32'd0);

    // +2/+2 on sample 5 is within tolerance
    clearOffs(); offX[5] = 2; offY[5] = 2;
    runVec();
    chk("tol_edge_pass", 32'(pass), 32'd1);

    // +3 on sample 9 fails
    clearOffs(); offX[9] = 3;
    runVec();
    chk("tol_over_err", 32'(err_cnt), 32'd1);
    chk("tol_over_pass", 32'(pass), 32'd0);

    // both components wrong counts once
    clearOffs(); offX[2] = 100; offY[2] = 100;
    runVec();
    chk("both_wrong_err", 32'(err_cnt), 32'd1);

    // sign-flipped X on sample 0
    clearOffs(); offX[0] = 2 * GA;
    runVec();
    chk("sign_flip_err", 32'(err_cnt), 32'd1);

    // spaced valids
    clearOffs();
    for (int k = 0; k < 16; k++) gapV[k] = 5;
    runVec();
    chk("spaced_pass", 32'(pass), 32'd1);

    // stall after sample 7
    clearOffs();
    pulseStart();
    for (int k = 0; k < 8; k++) sendSample(k, 0, 0);
`ifdef CORDIC_CHK_TIMEOUT_EN
    waitDone(1100, n);
    chk("timeout_idle_cycles", 32'(n), 32'(TIMEOUT));
    chk("timeout_flag", 32'(timeout), 32'd1);
    chk("timeout_done", 32'(done), 32'd1);
    chk("timeout_idx", 32'(idx), 32'd8);
    chk("timeout_pass", 32'(pass), 32'd0);
`else
    idle(1100);
    chk("nowd_busy", 32'(busy), 32'd1);
    chk("nowd_timeout", 32'(timeout), 32'd0);
    chk("nowd_done", 32'(done), 32'd0);
    chk("nowd_idx", 32'(idx), 32'd8);
`endif

    // asynchronous reset after sample 10
    clearOffs(); offX[3] = 50;
    pulseStart();
    for (int k = 0; k < 11; k++) sendSample(k, offX[k], 0);
    #2 nGrst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_idx", 32'(idx), 32'd0);
    chk("arst_err", 32'(err_cnt), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    #9 nGrst = 1'b1;
    @(negedge clk);
    clearOffs();
    runVec();
    chk("post_arst_pass", 32'(pass), 32'd1);

    // restart at idx 6 with a colliding (bad) valid
    clearOffs();
    pulseStart();
    for (int k = 0; k < 6; k++) sendSample(k, (k == 3) ? 50 : 0, 0);
    chk("pre_restart_err", 32'(err_cnt), 32'd1);
    chk("pre_restart_idx", 32'(idx), 32'd6);
    start = 1'b1;
    dut_valid = 1'b1;
    dut_x = 32'(goldX[6] + 1000);
    dut_y = 32'(goldY[6]);
    @(negedge clk);
    start = 1'b0;
    dut_valid = 1'b0;
    chk("restart_idx", 32'(idx), 32'd0);
    chk("restart_err", 32'(err_cnt), 32'd0);
    idle(1);
    chk("restart_discard_err", 32'(err_cnt), 32'd0);
    for (int k = 0; k < 16; k++) sendSample(k, 0, 0);
    waitDone(40, n);
    chk("restart_pass", 32'(pass), 32'd1);

    // randomized runs
    for (int r = 0; r < 24; r++) begin
      clearOffs();
      expErr = 0;
      for (int k = 0; k < 16; k++) begin
        offX[k] = pickOff();
        offY[k] = pickOff();
        gapV[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        if (absL(offX[k]) > longint'(TOL) || absL(offY[k]) > longint'(TOL)) expErr++;
      end
      runVec();
      chk("rand_err", 32'(err_cnt), 32'(expErr));
      chk("rand_pass", 32'(pass), 32'(expErr == 0));
      sendSample(int'($urandom_range(0, 15)), 500, 0);
      idle(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
